fcs_append_ctrl: RTL and testbench

Frame-check-sequence sequencer for the ARP/Ethernet transmit path. Accepts a byte stream one frame at a time and drives the external `crc_32_byte` engine through its `data_in`/`crc_en`/`clr` ports. Zero-pads short frames up to `MIN_PAYLOAD` bytes, then appends the 4 FCS bytes. Its output is a registered valid/ready byte stream toward the MAC/PHY serializer.

---
 rtl/fcs_append_ctrl.sv | 128 ++++++++++++
 tb/tb_fcs_append_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcs_append_ctrl.sv
// Appends a zero-pad and 4-byte FCS to each frame, steering an external CRC-32 byte engine.
// Latency: one cycle from input accept to out_data; one byte per cycle when out_ready is held high.
// Backpressure: out_ready low with out_valid high freezes the output, state, counters, crc_en and in_ready.
module fcs_append_ctrl #(
  parameter int MIN_PAYLOAD = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [7:0]  crc_data,
  output logic        crc_en,
  output logic        crc_clr,
  input  logic [31:0] crc_in,
  input  logic        crc_rdy
);

  // Counter only needs to reach MIN_PAYLOAD; it saturates there for long frames.
  localparam int            CW    = (MIN_PAYLOAD < 1) ? 1 : $clog2(MIN_PAYLOAD + 1);
  localparam logic [CW:0]   MIN_W = (CW+1)'(MIN_PAYLOAD);

  typedef enum logic [1:0] {ST_DATA, ST_PAD, ST_FCS} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            ld;
  logic [CW:0]     cnt_inc;
  logic [CW-1:0]   cnt_sat;

  // The output register may take a new byte when empty or being drained this cycle.
  assign ld       = !valid_q || out_ready;
  assign in_ready = (state_q == ST_DATA) && ld;

  // Unsaturated increment drives the pad/FCS decisions; the stored count saturates.
  assign cnt_inc  = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
  assign cnt_sat  = (cnt_inc >= MIN_W) ? MIN_W[CW-1:0] : cnt_inc[CW-1:0];

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

  // Next-state, output-register load and CRC engine strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    valid_d  = valid_q && !out_ready;
    last_d   = last_q && !out_ready;
    crc_en   = 1'b0;
    crc_clr  = 1'b0;
    crc_data = 8'h00;
    case (state_q)
      ST_DATA: begin
        if (in_valid) crc_data = in_data;
        if (in_valid && ld) begin
          data_d  = in_data;
          valid_d = 1'b1;
          last_d  = 1'b0;
          crc_en  = 1'b1;
          cnt_d   = cnt_sat;
          if (in_last) begin
            idx_d   = 2'd0;
            state_d = (cnt_inc < MIN_W) ? ST_PAD : ST_FCS;
          end
        end
      end
      ST_PAD: begin
        if (ld) begin
          data_d  = 8'h00;
          valid_d = 1'b1;
          last_d  = 1'b0;
          crc_en  = 1'b1;
          cnt_d   = cnt_sat;
          if (cnt_inc == MIN_W) begin
            idx_d   = 2'd0;
            state_d = ST_FCS;
          end
        end
      end
      ST_FCS: begin
        // crc_in is stable here since crc_en stays low; a not-ready engine just stalls.
        if (ld && crc_rdy) begin
          data_d  = crc_in[{idx_q, 3'b000} +: 8];
          valid_d = 1'b1;
          last_d  = (idx_q == 2'd3);
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            crc_clr = 1'b1;
            cnt_d   = '0;
            state_d = ST_DATA;
          end
        end
      end
      default: state_d = ST_DATA;
    endcase
  end

  // State, counters and the registered output byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_DATA;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_fcs_append_ctrl.sv
// Bench for fcs_append_ctrl: two instances (no padding, 60-byte padding), each with a CRC-32 engine model.
module tb_fcs_append_ctrl;

  typedef logic [8:0] beat_t;  // {last, data}

  typedef struct {
    logic       vld;
    logic [7:0] dat;
    logic       lst;
    logic       ordy;
    logic       irdy;
    logic       en;
    logic [7:0] cdat;
    logic       clr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0][7:0]  in_data, out_data, crc_data;
  logic [1:0]       in_valid, in_last, in_ready, out_valid, out_last, out_ready;
  logic [1:0]       crc_en, crc_clr, crc_rdy;
  logic [1:0][31:0] crc_reg;

  fcs_append_ctrl #(.MIN_PAYLOAD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_last(in_last[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_last(out_last[0]), .out_ready(out_ready[0]),
    .crc_data(crc_data[0]), .crc_en(crc_en[0]), .crc_clr(crc_clr[0]),
    .crc_in(~crc_reg[0]), .crc_rdy(crc_rdy[0])
  );

  fcs_append_ctrl #(.MIN_PAYLOAD(60)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_last(in_last[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_last(out_last[1]), .out_ready(out_ready[1]),
    .crc_data(crc_data[1]), .crc_en(crc_en[1]), .crc_clr(crc_clr[1]),
    .crc_in(~crc_reg[1]), .crc_rdy(crc_rdy[1])
  );

  // Reflected CRC-32 (poly 0xEDB88320), one byte per call.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Engine models: registered, shared reset, clear has priority.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_reg <= {2{32'hFFFFFFFF}};
    else for (int d = 0; d < 2; d++) begin
      if (crc_clr[d])     crc_reg[d] <= 32'hFFFFFFFF;
      else if (crc_en[d]) crc_reg[d] <= crc_upd(crc_reg[d], crc_data[d]);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor and event counters, sampled away from the active edge.
  beat_t obs [2][512];
  int    obs_n[2], en_cnt[2], clr_cnt[2], last_cnt[2], irdy_low[2];
  always @(negedge clk) begin
    if (rst_n) for (int d = 0; d < 2; d++) begin
      if (out_valid[d] && out_ready[d]) begin
        if (obs_n[d] < 512) obs[d][obs_n[d]] = {out_last[d], out_data[d]};
        obs_n[d]++;
        if (out_last[d]) last_cnt[d]++;
      end
      if (crc_en[d])    en_cnt[d]++;
      if (crc_clr[d])   clr_cnt[d]++;
      if (!in_ready[d]) irdy_low[d]++;
    end
  end

  // Random backpressure on instance 1.
  bit bp_on = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    if (bp_on) out_ready[1] = 1'($urandom_range(0, 1));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: pad to the minimum, then the final CRC bytes, low byte first.
  beat_t exp_q[$];
  int    exp_en;
  task automatic add_exp(input int minp, input logic [7:0] f[$]);
    logic [7:0]  blk[$];
    logic [31:0] c;
    blk = f;
    while (blk.size() < minp) blk.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (blk[i]) c = crc_upd(c, blk[i]);
    c = ~c;
    foreach (blk[i]) exp_q.push_back({1'b0, blk[i]});
    for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, c[8*k +: 8]});
    exp_en += blk.size();
  endtask

  task automatic exp_check_value();
    logic [7:0] v[13];
    v = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
    exp_q.delete();
    for (int i = 0; i < 13; i++) exp_q.push_back({i == 12, v[i]});
  endtask

  task automatic clear_counters(input int d);
    obs_n[d] = 0; en_cnt[d] = 0; clr_cnt[d] = 0; last_cnt[d] = 0; irdy_low[d] = 0;
  endtask

  // Present each byte until accepted; bubbles insert random idle cycles.
  task automatic send_frame(input int d, input logic [7:0] fr[$], input bit with_last,
                            input bit bubbles, output int cyc);
    bit acc;
    int w;
    cyc = 0;
    for (int i = 0; i < fr.size(); i++) begin
      if (bubbles) while ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; cyc++; end
      in_valid[d] = 1'b1;
      in_data[d]  = fr[i];
      in_last[d]  = with_last && (i == fr.size() - 1);
      acc = 1'b0;
      w   = 0;
      while (!acc && w < 2000) begin
        @(negedge clk);
        acc = in_ready[d];
        @(posedge clk); #1;
        cyc++; w++;
      end
      in_valid[d] = 1'b0;
      in_last[d]  = 1'b0;
      if (!acc) begin
        checks++; errors++;
        $display("FAIL accept_timeout: dut%0d byte %0d not accepted", d, i);
        return;
      end
    end
  endtask

  task automatic wait_drain(input int d, input int n);
    int w;
    w = 0;
    while (obs_n[d] < n && w < 5000) begin @(posedge clk); w++; end
    repeat (3) @(posedge clk);
    #1;
    if (obs_n[d] < n) begin
      checks++; errors++;
      $display("FAIL drain_timeout: dut%0d got %0d bytes expected %0d", d, obs_n[d], n);
    end
  endtask

  task automatic cmp_stream(input int d, input string name);
    int n;
    chk({name, "_len"}, obs_n[d], exp_q.size());
    n = (obs_n[d] < exp_q.size()) ? obs_n[d] : exp_q.size();
    if (n > 512) n = 512;
    for (int i = 0; i < n; i++) chk($sformatf("%s_b%0d", name, i), 32'(obs[d][i]), 32'(exp_q[i]));
  endtask

  vec_t       tbl[6];
  logic [7:0] fr[$];
  int         cyc;

  initial begin
    tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0};
    tbl[2] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[5] = '{1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 8'h81, 1'b0};

    rst_n = 1'b0;
    in_data = '0; in_valid = '0; in_last = '0;
    out_ready = 2'b11; crc_rdy = 2'b11;
    clear_counters(0); clear_counters(1);

    // Reset state and combinational strobes while held in reset.
    #2;
    for (int i = 0; i < 6; i++) begin
      in_valid[1] = tbl[i].vld; in_data[1] = tbl[i].dat;
      in_last[1]  = tbl[i].lst; out_ready[1] = tbl[i].ordy;
      #1;
      chk($sformatf("rst_in_ready_%0d", i), in_ready[1], tbl[i].irdy);
      chk($sformatf("rst_crc_en_%0d", i),   crc_en[1],   tbl[i].en);
      chk($sformatf("rst_crc_data_%0d", i), crc_data[1], tbl[i].cdat);
      chk($sformatf("rst_crc_clr_%0d", i),  crc_clr[1],  tbl[i].clr);
      chk($sformatf("rst_out_valid_%0d", i), out_valid[1], 1'b0);
      chk($sformatf("rst_out_last_%0d", i),  out_last[1],  1'b0);
      chk($sformatf("rst_out_data_%0d", i),  out_data[1],  8'h00);
    end
    in_valid = '0; in_data = '0; in_last = '0; out_ready = 2'b11;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Check value, MIN_PAYLOAD=0: first byte by hand to observe latency.
    clear_counters(0);
    in_valid[0] = 1'b1; in_data[0] = 8'h31; in_last[0] = 1'b0;
    @(negedge clk);
    chk("lat_in_ready", in_ready[0], 1'b1);
    chk("lat_crc_en",   crc_en[0],   1'b1);
    chk("lat_crc_data", crc_data[0], 8'h31);
    chk("lat_out_valid_before", out_valid[0], 1'b0);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("lat_out_valid_after", out_valid[0], 1'b1);
    chk("lat_out_data_after",  out_data[0],  8'h31);
    @(posedge clk); #1;
    fr = '{8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_frame(0, fr, 1'b1, 1'b0, cyc);
    chk("chkval_throughput", cyc, 8);
    wait_drain(0, 13);
    exp_check_value();
    cmp_stream(0, "chkval");
    chk("chkval_clr_pulses", clr_cnt[0], 1);
    chk("chkval_last_count", last_cnt[0], 1);
    chk("chkval_en_count",   en_cnt[0],   9);

    // Short frame padded to 60 bytes.
    clear_counters(1);
    exp_q.delete(); exp_en = 0;
    fr = '{8'hAA};
    add_exp(60, fr);
    send_frame(1, fr, 1'b1, 1'b0, cyc);
    wait_drain(1, 64);
    cmp_stream(1, "pad");
    chk("pad_in_ready_low", irdy_low[1], 63);
    chk("pad_en_count", en_cnt[1], 60);

    // Long frame: no padding, counter must not wrap.
    clear_counters(1);
    exp_q.delete(); exp_en = 0;
    fr.delete();
    for (int i = 0; i < 100; i++) fr.push_back(8'($urandom));
    add_exp(60, fr);
    send_frame(1, fr, 1'b1, 1'b0, cyc);
    chk("long_throughput", cyc, 100);
    wait_drain(1, 104);
    cmp_stream(1, "long");
    chk("long_en_count", en_cnt[1], 100);

    // Back-to-back frames with random backpressure and input bubbles.
    clear_counters(1);
    exp_q.delete(); exp_en = 0;
    bp_on = 1'b1;
    begin
      int lens[4];
      lens = '{5, 60, 61, 1};
      for (int f = 0; f < 4; f++) begin
        fr.delete();
        for (int i = 0; i < lens[f]; i++) fr.push_back(8'($urandom));
        add_exp(60, fr);
        send_frame(1, fr, 1'b1, 1'b1, cyc);
      end
    end
    wait_drain(1, exp_q.size());
    bp_on = 1'b0;
    @(posedge clk); #2;
    out_ready[1] = 1'b1;
    cmp_stream(1, "bp");
    chk("bp_en_count",   en_cnt[1],   exp_en);
    chk("bp_clr_count",  clr_cnt[1],  4);
    chk("bp_last_count", last_cnt[1], 4);

    // Engine not ready in FCS: block must stall without loading.
    clear_counters(0);
    exp_q.delete(); exp_en = 0;
    crc_rdy[0] = 1'b0;
    fr = '{8'h55};
    add_exp(0, fr);
    send_frame(0, fr, 1'b1, 1'b0, cyc);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("stall_out_valid", out_valid[0], 1'b0);
    chk("stall_in_ready",  in_ready[0],  1'b0);
    chk("stall_count",     obs_n[0],     1);
    @(posedge clk); #1;
    crc_rdy[0] = 1'b1;
    wait_drain(0, 5);
    cmp_stream(0, "stall");

    // Asynchronous reset in the middle of a frame.
    clear_counters(0);
    fr = '{8'h10, 8'h20, 8'h30, 8'h40};
    send_frame(0, fr, 1'b0, 1'b0, cyc);
    out_ready[0] = 1'b0;
    @(posedge clk); #2;
    chk("prerst_out_valid", out_valid[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid[0], 1'b0);
    chk("arst_in_ready",  in_ready[0],  1'b1);
    chk("arst_out_data",  out_data[0],  8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready[0] = 1'b1;
    clear_counters(0);
    fr = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_frame(0, fr, 1'b1, 1'b0, cyc);
    wait_drain(0, 13);
    exp_check_value();
    cmp_stream(0, "postrst");
    chk("postrst_clr_pulses", clr_cnt[0], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
